// File: rtl/rr_arb4.sv
// rr_arb4: four-way round-robin arbiter with grant hold and optional hold timeout.
//
// A granted requester keeps the resource while its req stays high. When it
// drops req, or has held for MAX_HOLD consecutive cycles, the grant moves to
// the next requester in rotating priority order. A release hands off with no
// idle cycle in between.
//
// Parameters
//   MAX_HOLD  max consecutive grant cycles per holder; 0 disables the timeout
//   CNT_W     hold counter width; MAX_HOLD must be < 2**CNT_W
//
// Ports
//   clk      in   1  clock, rising edge
//   rst      in   1  asynchronous active-high reset
//   req      in   4  level request per requester
//   gnt      out  4  one-hot grant (registered)
//   gnt_idx  out  2  binary index of gnt, 0 when no grant (registered)
//   gnt_vld  out  1  high when gnt != 0 (registered)
//   tmo      out  1  one-cycle pulse when the holder is revoked by timeout
module rr_arb4 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld,
    output logic       tmo
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam bit               TMO_EN   = (MAX_HOLD != 0);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic               gnt_vld_q, gnt_vld_d;
    logic               tmo_q, tmo_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

    logic               release_c;
    logic               timeout_c;
    logic [N_REQ-1:0]   cand_c;
    logic               win_vld_c;
    logic [IDX_W-1:0]   win_idx_c;

    // Holder status and the candidate mask fed to the arbiter.
    // With no holder (gnt_q == 0) release_c is true, so IDLE arbitrates on req.
    always_comb begin
        release_c = ((gnt_q & req) == '0);
        timeout_c = TMO_EN && (hold_cnt_q == HOLD_LIM) && !release_c;
        cand_c    = timeout_c ? (req & ~gnt_q) : req;
    end

    // Rotating-priority search: first set candidate starting at ptr_q, wrapping mod 4.
    always_comb begin
        logic [IDX_W-1:0] idx;
        win_vld_c = 1'b0;
        win_idx_c = '0;
        idx       = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = ptr_q + IDX_W'(k);
            if (!win_vld_c && cand_c[idx]) begin
                win_vld_c = 1'b1;
                win_idx_c = idx;
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        tmo_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_vld_c) begin
                    gnt_d      = N_REQ'(1) << win_idx_c;
                    ptr_d      = win_idx_c + IDX_W'(1);
                    hold_cnt_d = CNT_W'(1);
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (release_c || timeout_c) begin
                    // A drop coinciding with the limit counts as a release, not a timeout.
                    tmo_d = timeout_c;
                    if (win_vld_c) begin
                        gnt_d      = N_REQ'(1) << win_idx_c;
                        ptr_d      = win_idx_c + IDX_W'(1);
                        hold_cnt_d = CNT_W'(1);
                    end else begin
                        gnt_d      = '0;
                        hold_cnt_d = '0;
                        state_d    = IDLE;
                    end
                end else if (hold_cnt_q != CNT_SAT) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        gnt_idx_d = {gnt_d[3] | gnt_d[2], gnt_d[3] | gnt_d[1]};
        gnt_vld_d = |gnt_d;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            gnt_vld_q  <= 1'b0;
            tmo_q      <= 1'b0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_vld_q  <= gnt_vld_d;
            tmo_q      <= tmo_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = gnt_vld_q;
    assign tmo     = tmo_q;

endmodule

// File: tb/tb_rr_arb4.sv
// tb_rr_arb4: checks three rr_arb4 instances (MAX_HOLD = 4, 0, 16) driven by
// shared req/rst against a behavioural model of holder / priority / run length.
module tb_rr_arb4;

    localparam int NI  = 3;
    localparam int I4  = 0;
    localparam int I0  = 1;
    localparam int I16 = 2;
    localparam int unsigned MH [NI] = '{4, 0, 16};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;

    logic [3:0] gnt_o [NI];
    logic [1:0] idx_o [NI];
    logic       vld_o [NI];
    logic       tmo_o [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        rr_arb4 #(.MAX_HOLD(MH[g]), .CNT_W(8)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .req     (req),
            .gnt     (gnt_o[g]),
            .gnt_idx (idx_o[g]),
            .gnt_vld (vld_o[g]),
            .tmo     (tmo_o[g])
        );
    end

    // ---------------- behavioural model ----------------
    typedef struct {
        int holder;   // -1 = nobody holds the resource
        int ptr;      // highest-priority index
        int run;      // consecutive cycles the holder has owned the grant
        bit tmo;
    } mstate_t;

    mstate_t ms [NI];

    function automatic int pick(input logic [3:0] m, input int p);
        for (int k = 0; k < 4; k++) begin
            if (m[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic mstate_t step(input mstate_t s, input logic [3:0] r, input int mh);
        mstate_t    n;
        int         w;
        logic [3:0] m;
        n     = s;
        n.tmo = 1'b0;
        w     = -1;
        m     = r;
        if (n.holder >= 0 && r[n.holder] && !(mh != 0 && n.run == mh)) begin
            if (n.run < 255) n.run = n.run + 1;
        end else begin
            if (n.holder >= 0 && r[n.holder]) begin
                n.tmo       = 1'b1;
                m[n.holder] = 1'b0;
            end
            w = pick(m, n.ptr);
            if (w >= 0) begin
                n.holder = w;
                n.ptr    = (w + 1) % 4;
                n.run    = 1;
            end else begin
                n.holder = -1;
                n.run    = 0;
            end
        end
        return n;
    endfunction

    function automatic int exp_gnt(input mstate_t s);
        return (s.holder < 0) ? 0 : (1 << s.holder);
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) ms[i] <= '{-1, 0, 0, 1'b0};
            else     ms[i] <= step(ms[i], req, int'(MH[i]));
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("model_gnt[%0d]", i), int'(gnt_o[i]), exp_gnt(ms[i]));
            chk($sformatf("model_idx[%0d]", i), int'(idx_o[i]), (ms[i].holder < 0) ? 0 : ms[i].holder);
            chk($sformatf("model_vld[%0d]", i), int'(vld_o[i]), (ms[i].holder < 0) ? 0 : 1);
            chk($sformatf("model_tmo[%0d]", i), int'(tmo_o[i]), int'(ms[i].tmo));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        req = 4'b0000;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s_gnt[%0d]", tag, i), int'(gnt_o[i]), 0);
            chk($sformatf("%s_idx[%0d]", tag, i), int'(idx_o[i]), 0);
            chk($sformatf("%s_vld[%0d]", tag, i), int'(vld_o[i]), 0);
            chk($sformatf("%s_tmo[%0d]", tag, i), int'(tmo_o[i]), 0);
        end
    endtask

    // Reset asserted mid-cycle must clear outputs without a clock edge.
    task automatic reset_mid();
        #($urandom_range(0, 2));
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        req = 4'b0000;
        cyc();
        rst = 1'b0;
        repeat (2) begin
            cyc();
            chk_all_zero("post_rst_idle");
        end
    endtask

    initial begin
        // Reset state and idle after release
        #1 rst = 1'b1;
        #1;
        chk_all_zero("reset");
        cyc();
        rst = 1'b0;
        repeat (3) begin
            cyc();
            chk_all_zero("idle_after_reset");
        end

        // Zero-gap handoff 0 -> 2
        req = 4'b0101;
        cyc();
        chk("handoff_first_gnt", int'(gnt_o[I16]), 1);
        chk("handoff_first_idx", int'(idx_o[I16]), 0);
        req = 4'b0100;
        cyc();
        chk("handoff_second_gnt", int'(gnt_o[I16]), 4);
        chk("handoff_second_idx", int'(idx_o[I16]), 2);
        chk("handoff_second_vld", int'(vld_o[I16]), 1);

        // Round-robin order 0,1,2,3,0 with one-cycle drops
        do_reset();
        req = 4'b1111;
        cyc();
        chk("rr_first_gnt", int'(gnt_o[I16]), 1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("rr_hold_vld", int'(vld_o[I16]), 1);
            req = 4'b1111 & ~(4'b0001 << k);
            cyc();
            req = 4'b1111;
            chk("rr_order_gnt", int'(gnt_o[I16]), 1 << ((k + 1) % 4));
            chk("rr_order_vld", int'(vld_o[I16]), 1);
        end

        // Timeout with a competitor (MAX_HOLD=4)
        do_reset();
        req = 4'b0011;
        repeat (4) begin
            cyc();
            chk("tmo2_hold0_gnt", int'(gnt_o[I4]), 1);
            chk("tmo2_hold0_tmo", int'(tmo_o[I4]), 0);
        end
        cyc();
        chk("tmo2_switch1_gnt", int'(gnt_o[I4]), 2);
        chk("tmo2_switch1_tmo", int'(tmo_o[I4]), 1);
        repeat (3) begin
            cyc();
            chk("tmo2_hold1_gnt", int'(gnt_o[I4]), 2);
            chk("tmo2_hold1_tmo", int'(tmo_o[I4]), 0);
        end
        cyc();
        chk("tmo2_switch0_gnt", int'(gnt_o[I4]), 1);
        chk("tmo2_switch0_tmo", int'(tmo_o[I4]), 1);

        // Timeout with no competitor: one idle cycle, then re-win
        do_reset();
        req = 4'b1000;
        repeat (4) begin
            cyc();
            chk("tmo1_hold_gnt", int'(gnt_o[I4]), 8);
            chk("tmo1_hold_tmo", int'(tmo_o[I4]), 0);
        end
        cyc();
        chk("tmo1_revoke_gnt", int'(gnt_o[I4]), 0);
        chk("tmo1_revoke_vld", int'(vld_o[I4]), 0);
        chk("tmo1_revoke_tmo", int'(tmo_o[I4]), 1);
        cyc();
        chk("tmo1_rewin_gnt", int'(gnt_o[I4]), 8);
        chk("tmo1_rewin_idx", int'(idx_o[I4]), 3);
        chk("tmo1_rewin_tmo", int'(tmo_o[I4]), 0);

        // Unlimited hold: counter saturation must not disturb the grant
        do_reset();
        req = 4'b0001;
        repeat (300) begin
            cyc();
            chk("nolimit_gnt", int'(gnt_o[I0]), 1);
            chk("nolimit_tmo", int'(tmo_o[I0]), 0);
        end

        // Randomized traffic with occasional asynchronous reset
        do_reset();
        repeat (3000) begin
            if ($urandom_range(0, 299) == 0) begin
                reset_mid();
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
                end
                cyc();
            end
        end

        req = 4'b0000;
        cyc();
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
